// File: rtl/ffn_mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ffn_mm_pkg
// Purpose  : Shared types and defaults for the FFN layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ffn_mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        NEXT = 2'd3
    } state_t;

    localparam int c_NUM_IN_DEF  = 64;
    localparam int c_NUM_OUT_DEF = 10;
    localparam int c_NUM_BUF_DEF = 2;

    // Counter width that still works when the count is 1.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_FA_W_DEF = width_of(c_NUM_IN_DEF);
    localparam int c_WA_W_DEF = width_of(c_NUM_IN_DEF * c_NUM_OUT_DEF);
    localparam int c_NO_W_DEF = width_of(c_NUM_OUT_DEF);

endpackage
`default_nettype wire

// File: rtl/ffn_mm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ffn_mm_sequencer_if
// Purpose  : Control/address bundle between the sequencer, buffers and MAC.
// Revision : 1.0 - initial release
// ============================================================================
interface ffn_mm_sequencer_if #(
    parameter int NUM_BUF = 2,
    parameter int FA_W    = 6,
    parameter int WA_W    = 10,
    parameter int NO_W    = 4
);
    logic               start;
    logic [NUM_BUF-1:0] frame_rdy;
    logic [NUM_BUF-1:0] reading_frame;
    logic [NUM_BUF-1:0] frame_release;
    logic [FA_W-1:0]    buf_addr;
    logic [WA_W-1:0]    weight_addr;
    logic               mac_en;
    logic               mac_first;
    logic               sum_valid;
    logic [NO_W-1:0]    neuron_idx;
    logic               busy;

    modport master (
        output start, frame_rdy,
        input  reading_frame, frame_release, buf_addr, weight_addr,
               mac_en, mac_first, sum_valid, neuron_idx, busy
    );

    modport slave (
        input  start, frame_rdy,
        output reading_frame, frame_release, buf_addr, weight_addr,
               mac_en, mac_first, sum_valid, neuron_idx, busy
    );
endinterface
`default_nettype wire

// File: rtl/ffn_mm_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ffn_mm_addr_gen
// Purpose  : Product/neuron counters and running weight ROM address.
// Revision : 1.0 - initial release
// ============================================================================
module ffn_mm_addr_gen
    import ffn_mm_pkg::*;
#(
    parameter int NUM_IN  = c_NUM_IN_DEF,
    parameter int NUM_OUT = c_NUM_OUT_DEF,
    parameter int FA_W    = c_FA_W_DEF,
    parameter int WA_W    = c_WA_W_DEF,
    parameter int NO_W    = c_NO_W_DEF
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            i_clear,
    input  wire logic            i_inc_k,
    input  wire logic            i_next_neuron,
    output logic [FA_W-1:0]      o_k,
    output logic [NO_W-1:0]      o_neuron,
    output logic [WA_W-1:0]      o_waddr,
    output logic                 o_last_k,
    output logic                 o_last_neuron
);

    localparam logic [FA_W-1:0] c_K_LAST      = FA_W'(NUM_IN - 1);
    localparam logic [NO_W-1:0] c_NEURON_LAST = NO_W'(NUM_OUT - 1);

    logic [FA_W-1:0] r_k;
    logic [NO_W-1:0] r_neuron;
    logic [WA_W-1:0] r_waddr;

    // weight address runs contiguously across neurons, so it is a plain
    // increment rather than neuron*NUM_IN+k
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_k      <= '0;
            r_neuron <= '0;
            r_waddr  <= '0;
        end else if (i_next_neuron) begin
            r_k      <= '0;
            r_neuron <= r_neuron + 1'b1;
            r_waddr  <= r_waddr + 1'b1;
        end else if (i_inc_k) begin
            r_k      <= r_k + 1'b1;
            r_waddr  <= r_waddr + 1'b1;
        end
    end

    assign o_k           = r_k;
    assign o_neuron      = r_neuron;
    assign o_waddr       = r_waddr;
    assign o_last_k      = (r_k == c_K_LAST);
    assign o_last_neuron = (r_neuron == c_NEURON_LAST);

endmodule
`default_nettype wire

// File: rtl/ffn_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ffn_mm_sequencer
// Purpose  : Walks the MAC lane through a fully-connected layer per frame.
// Revision : 1.0 - initial release
// ============================================================================
module ffn_mm_sequencer
    import ffn_mm_pkg::*;
#(
    parameter int NUM_IN  = c_NUM_IN_DEF,
    parameter int NUM_OUT = c_NUM_OUT_DEF,
    parameter int NUM_BUF = c_NUM_BUF_DEF,
    parameter int FA_W    = width_of(NUM_IN),
    parameter int WA_W    = width_of(NUM_IN * NUM_OUT),
    parameter int NO_W    = width_of(NUM_OUT)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    ffn_mm_sequencer_if.slave bus
);

    localparam logic [NUM_BUF-1:0] c_BUF0 = NUM_BUF'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_BUF-1:0] r_reading;
    logic               w_clear;
    logic               w_inc_k;
    logic               w_next_neuron;
    logic               w_release;
    logic               w_issue;
    logic [FA_W-1:0]    w_k;
    logic [NO_W-1:0]    w_neuron;
    logic [WA_W-1:0]    w_waddr;
    logic               w_last_k;
    logic               w_last_neuron;
    logic               r_d1_en;
    logic               r_d1_first;
    logic               r_d1_last;
    logic [NO_W-1:0]    r_d1_neuron;
    logic               r_sum_valid;
    logic [NO_W-1:0]    r_neuron_idx;

    ffn_mm_addr_gen #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT),
        .FA_W    (FA_W),
        .WA_W    (WA_W),
        .NO_W    (NO_W)
    ) u_addr_gen (
        .clock         (clock),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_inc_k       (w_inc_k),
        .i_next_neuron (w_next_neuron),
        .o_k           (w_k),
        .o_neuron      (w_neuron),
        .o_waddr       (w_waddr),
        .o_last_k      (w_last_k),
        .o_last_neuron (w_last_neuron)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // counters are cleared on leaving WAIT so addresses hold while waiting
    always_comb begin
        w_state_nxt   = r_state;
        w_clear       = 1'b0;
        w_inc_k       = 1'b0;
        w_next_neuron = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            IDLE: if (bus.start) w_state_nxt = WAIT;
            WAIT: if ((bus.frame_rdy & r_reading) != '0) begin
                w_clear     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last_k) w_state_nxt = NEXT;
                else          w_inc_k     = 1'b1;
            end
            NEXT: begin
                if (w_last_neuron) begin
                    w_release   = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_next_neuron = 1'b1;
                    w_state_nxt   = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)          r_reading <= c_BUF0;
        else if (w_release) r_reading <= {r_reading[NUM_BUF-2:0], r_reading[NUM_BUF-1]};
    end

    assign w_issue = (r_state == RUN);

    // stage 1 lines up with returned read data, stage 2 with the registered sum
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d1_en      <= 1'b0;
            r_d1_first   <= 1'b0;
            r_d1_last    <= 1'b0;
            r_d1_neuron  <= '0;
            r_sum_valid  <= 1'b0;
            r_neuron_idx <= '0;
        end else begin
            r_d1_en     <= w_issue;
            r_d1_first  <= w_issue && (w_k == '0);
            r_d1_last   <= w_issue && w_last_k;
            r_d1_neuron <= w_neuron;
            r_sum_valid <= r_d1_last;
            if (r_d1_last) r_neuron_idx <= r_d1_neuron;
        end
    end

    assign bus.reading_frame = r_reading;
    assign bus.frame_release = w_release ? r_reading : '0;
    assign bus.buf_addr      = w_k;
    assign bus.weight_addr   = w_waddr;
    assign bus.mac_en        = r_d1_en;
    assign bus.mac_first     = r_d1_first;
    assign bus.sum_valid     = r_sum_valid;
    assign bus.neuron_idx    = r_neuron_idx;
    assign bus.busy          = (r_state != IDLE);

endmodule
`default_nettype wire
